// File: rtl/lsu_axi_master_if.sv
// rtl/lsu_axi_master_if.sv - AXI4-Lite bus bundle between the LSU and master port 1 of the arbiter
interface lsu_axi_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic                rready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic                bready;
    logic [1:0]          bresp;
    logic                bvalid;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/lsu_axi_master.sv
// rtl/lsu_axi_master.sv - LSU bus front-end running one AXI4-Lite load or store at a time
// Optional macro LSU_MISALIGN_CHECK_EN: reject misaligned accesses instead of aligning them down.
module lsu_axi_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    lsu_axi_master_if.master  bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AWW  = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic              aw_done;
    logic              w_done;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [ADDR_W-1:0] eff_addr;
    logic              misaligned;
    logic [DATA_W-1:0] lane_data;
    logic [DATA_W-1:0] load_ext;
    logic [3:0]        strb_base;

    // Sub-word accesses are aligned down; when the check is enabled misaligned ones never reach the bus.
    always_comb begin
        eff_addr = req_addr;
        if (req_size == 2'd1) begin
            eff_addr[0] = 1'b0;
        end else if (req_size[1]) begin
            eff_addr[1:0] = 2'b00;
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = (req_size == 2'd1 && req_addr[0]) ||
                        (req_size[1] && req_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign lane_data = bus.rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = lane_data;
        case (size_q)
            2'd0:    load_ext = {{24{lane_data[7] & ~unsigned_q}}, lane_data[7:0]};
            2'd1:    load_ext = {{16{lane_data[15] & ~unsigned_q}}, lane_data[15:0]};
            default: load_ext = lane_data;
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0:    strb_base = 4'b0001;
            2'd1:    strb_base = 4'b0011;
            default: strb_base = 4'b1111;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q     <= eff_addr;
                        wdata_q    <= req_wdata;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        rdata_q    <= '0;
                        err_q      <= misaligned;
                        if (misaligned) begin
                            state <= S_RESP;
                        end else if (req_wen) begin
                            state <= S_AWW;
                        end else begin
                            state <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (bus.arready) begin
                        state <= S_R;
                    end
                end
                S_R: begin
                    if (bus.rvalid) begin
                        rdata_q <= load_ext;
                        err_q   <= (bus.rresp != 2'b00);
                        state   <= S_RESP;
                    end
                end
                S_AWW: begin
                    if (bus.awready) begin
                        aw_done <= 1'b1;
                    end
                    if (bus.wready) begin
                        w_done <= 1'b1;
                    end
                    // AW and W may complete in either order; leave once both have.
                    if ((aw_done | bus.awready) && (w_done | bus.wready)) begin
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (bus.bvalid) begin
                        err_q <= (bus.bresp != 2'b00);
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign bus.araddr  = addr_q;
    assign bus.arvalid = (state == S_AR);
    assign bus.rready  = (state == S_R);
    assign bus.awaddr  = addr_q;
    assign bus.awvalid = (state == S_AWW) && !aw_done;
    assign bus.wdata   = wdata_q << {addr_q[1:0], 3'b000};
    assign bus.wstrb   = strb_base << addr_q[1:0];
    assign bus.wvalid  = (state == S_AWW) && !w_done;
    assign bus.bready  = (state == S_B);
endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
Load/store unit bus front-end. Accepts one load or store request at a time from the execute/memory stage and runs it as a single AXI4-Lite transaction: AR/R for loads, AW/W/B for stores. Its bus-side ports connect directly to master port 1 of the two-master arbiter, which routes to CLINT or the SoC. It performs byte-lane steering, write-strobe generation, and sign or zero extension of load data.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; fixed at 32, other values unsupported

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  high only in IDLE
req_wen  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word
req_unsigned  in  1  load zero-extend when 1, sign-extend when 0
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores
resp_err  out  1  bus error or misaligned access
araddr  out  32  read address
arvalid  out  1  read address valid
arready  in  1  read address ready
rready  out  1  read data ready
rdata  in  32  read data
rresp  in  2  read response
rvalid  in  1  read data valid
awaddr  out  32  write address
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  32  write data
wstrb  out  4  write strobes
wvalid  out  1  write data valid
wready  in  1  write data ready
bready  out  1  write response ready
bresp  in  2  write response
bvalid  in  1  write response valid

Behaviour:
- Reset: state = IDLE; all valid/ready outputs = 0; resp_rdata = 0; resp_err = 0; aw_done = w_done = 0. Reset mid-transaction abandons the transfer; all valids drop the cycle after reset is sampled.
- States: IDLE, AR, R, AWW, B, RESP.
- IDLE: req_ready = 1. On req_valid, latch addr, wdata, size, unsigned and wen.
  - Misaligned request (half with addr[0] = 1, or word with addr[1:0] != 0): go to RESP with resp_err = 1; no bus activity.
  - Aligned load: go to AR.
  - Aligned store: go to AWW.
- AR:
  - arvalid = 1, araddr = latched addr.
  - arvalid and araddr stay stable until arready; arready may stay 0 for any number of cycles while the arbiter grants.
  - On arready, go to R.
- R:
  - rready = 1.
  - On rvalid, select lane rdata >> (8*addr[1:0]).
  - Truncate to size, then sign- or zero-extend. Word loads pass through.
  - Latch the result and err = (rresp != 0); go to RESP.
- AWW:
  - awvalid and wvalid are asserted in the same cycle as each other.
  - awaddr = addr; wdata = req_wdata << (8*addr[1:0]).
  - wstrb: byte 4'b0001, half 4'b0011, word 4'b1111, each shifted left by addr[1:0].
  - aw_done is set on awready and w_done on wready; each valid drops after its own handshake, which may come in either order or the same cycle.
  - When both are done (including the current cycle), go to B.
- B:
  - bready = 1.
  - On bvalid, err = (bresp != 0); go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, with resp_rdata and resp_err driven.
  - Return to IDLE. No back-pressure on the response.
- Latency:
  - Load with zero-wait slave (arready in AR, rvalid in the first R cycle): accept -> resp_valid in 3 cycles.
  - Store with zero-wait slave: 3 cycles.
  - Misaligned request: 1 cycle.
- No new request is accepted before the RESP cycle completes, so at most one transaction is outstanding.
- Spurious rvalid or bvalid outside R or B is ignored.

Optional Feature:
Macro: LSU_MISALIGN_CHECK_EN.
- Defined: misaligned requests complete with resp_err = 1 and no bus transaction, as described above.
- Undefined: no alignment check. Half accesses force addr[0] = 0 and word accesses force addr[1:0] = 0 on the bus and in lane selection; resp_err reflects rresp/bresp only.

Test Plan:
- Word load at 0x8000_0010, slave arready = 1, rdata = 0xDEADBEEF, rresp = 0 -> araddr = 0x8000_0010; resp_rdata = 0xDEADBEEF, resp_err = 0, resp_valid 3 cycles after accept.
- Signed byte load at 0x8000_0013, rdata = 0x80AA_BBCC -> resp_rdata = 0xFFFF_FF80. Unsigned half load at 0x8000_0012 with the same rdata -> 0x0000_80AA.
- Byte store of 0x5A at 0x8000_0021 -> wdata = 0x0000_5A00, wstrb = 4'b0010. Slave gives wready 2 cycles before awready -> exactly one W handshake and one AW handshake, then bready; bvalid with bresp = 2 -> resp_err = 1.
- arready held low 5 cycles (arbiter not granting) -> arvalid and araddr stable throughout; completion is correct afterwards.
- Word load at 0x8000_0002 -> with LSU_MISALIGN_CHECK_EN: resp_err = 1 after 1 cycle, arvalid never asserted. Without the macro: araddr = 0x8000_0000.
- Reset asserted while in R -> next cycle rready = 0, req_ready = 1; a fresh load completes normally.
